// File: rtl/three_lane_demux_if.sv
// Bus bundle for three_lane_demux: the serial sample stream in, the three-lane
// frame stream out, plus the frame counter and a debug view of the lane pointer.
interface three_lane_demux_if #(
   parameter int SAMPLE_W = 16,
   parameter int CNT_W    = 16
);
   // Handshakes: a transfer happens on a posedge where valid and ready are both 1;
   // the source holds its payload stable until then, and ready never looks at valid.
   logic                       in_valid;
   logic signed [SAMPLE_W-1:0] in_data;
   logic                       in_ready;
   logic                       flush;
   logic                       out_valid;
   logic                       out_ready;
   logic signed [SAMPLE_W-1:0] out_x0;
   logic signed [SAMPLE_W-1:0] out_x1;
   logic signed [SAMPLE_W-1:0] out_x2;
   logic                       out_pad;
   logic [CNT_W-1:0]           frame_cnt;
   logic [1:0]                 dbg_lane;

   modport master (
      output in_valid, in_data, flush, out_ready,
      input  in_ready, out_valid, out_x0, out_x1, out_x2, out_pad, frame_cnt, dbg_lane
   );

   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output in_ready, out_valid, out_x0, out_x1, out_x2, out_pad, frame_cnt, dbg_lane
   );
endinterface

// File: rtl/three_lane_demux.sv
// Serial-to-three-parallel demux feeding a three-parallel filter: gathers x(3k),
// x(3k+1), x(3k+2) into one registered frame, with flush-driven zero padding.
module three_lane_demux #(
   parameter int SAMPLE_W = 16,
   parameter int CNT_W    = 16
) (
   input logic               clk,
   input logic               rst,
   three_lane_demux_if.slave bus
);
   typedef enum logic [1:0] {
      LANE0 = 2'd0,
      LANE1 = 2'd1,
      LANE2 = 2'd2
   } lane_t;

   lane_t                      lane_q, lane_d, lane_acc;
   logic signed [SAMPLE_W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
   logic signed [SAMPLE_W-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
   logic signed [SAMPLE_W-1:0] g0, g1;
   logic                       valid_q, valid_d, pad_q, pad_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       slot_free, accept, deliver, close_full, flush_ok, load;

   // Only lanes 0 and 1 need gather storage: the lane-2 sample goes straight
   // into the output frame on the cycle it is accepted.
   always_comb begin
      deliver    = valid_q && bus.out_ready;
      slot_free  = !valid_q || bus.out_ready;
      accept     = bus.in_valid && ((lane_q != LANE2) || slot_free);
      close_full = accept && (lane_q == LANE2);
      g0         = slot0_q;
      g1         = slot1_q;
      lane_acc   = lane_q;
      if (accept) begin
         unique case (lane_q)
            LANE0: begin
               g0       = bus.in_data;
               lane_acc = LANE1;
            end
            LANE1: begin
               g1       = bus.in_data;
               lane_acc = LANE2;
            end
            default: lane_acc = LANE0;
         endcase
      end
      // A flush only closes a frame that still has something in it after this
      // cycle's accept; a third sample closing the frame makes flush redundant.
      flush_ok = bus.flush && slot_free && (lane_acc != LANE0);
      load     = close_full || flush_ok;

      lane_d  = lane_acc;
      slot0_d = g0;
      slot1_d = g1;
      x0_d    = x0_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      pad_d   = pad_q;
      valid_d = valid_q;
      cnt_d   = deliver ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

      if (load) begin
         x0_d    = g0;
         x1_d    = g1;
         x2_d    = close_full ? bus.in_data : '0;
         pad_d   = !close_full;
         valid_d = 1'b1;
         lane_d  = LANE0;
         slot0_d = '0;
         slot1_d = '0;
      end else if (deliver) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_q  <= LANE0;
         slot0_q <= '0;
         slot1_q <= '0;
         x0_q    <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         pad_q   <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         lane_q  <= lane_d;
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         pad_q   <= pad_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = (lane_q != LANE2) || slot_free;
   assign bus.out_valid = valid_q;
   assign bus.out_x0    = x0_q;
   assign bus.out_x1    = x1_q;
   assign bus.out_x2    = x2_q;
   assign bus.out_pad   = pad_q;
   assign bus.frame_cnt = cnt_q;
   assign bus.dbg_lane  = lane_q;
endmodule
